// File: rtl/sequence_divider_8bit.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per clock; the trial subtraction R - D is built
// from a ripple chain of adder_4bit slices computing R + ~D + 1.
// WIDTH must be a multiple of 4 so that every nibble gets its own slice.

module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   // Plain 4-bit add with carry in/out, used as one nibble of the chain
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module sequence_divider_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CW  = $clog2(WIDTH);
   localparam int NIB = WIDTH / 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH-1:0] d_inv;
   logic [WIDTH-1:0] diff;
   logic [NIB:0]     carry;
   logic             accept;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;
   logic             last_iter;

   // Shift the next dividend bit into the partial remainder; the extra top
   // bit guarantees the subtraction succeeds whenever it is set
   assign r_sh     = {r_reg, q_reg[WIDTH-1]};
   assign d_inv    = ~d_reg;
   assign carry[0] = 1'b1;

   // Ripple chain of nibble adders forming R - D as R + ~D + 1
   for (genvar g = 0; g < NIB; g++) begin : g_sub
      adder_4bit u_add (
         .a    (r_sh[4*g +: 4]),
         .b    (d_inv[4*g +: 4]),
         .cin  (carry[g]),
         .sum  (diff[4*g +: 4]),
         .cout (carry[g+1])
      );
   end

   // Restoring step: keep the difference only when R >= D
   assign accept    = r_sh[WIDTH] | carry[NIB];
   assign r_next    = accept ? diff : r_sh[WIDTH-1:0];
   assign q_next    = {q_reg[WIDTH-2:0], accept};
   assign last_iter = (cnt == CW'(WIDTH - 1));

   assign busy_o = (state == ST_CALC);
   assign done_o = (state == ST_DONE);

   // Control FSM and datapath registers; results only change on entry to DONE
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state         <= ST_IDLE;
         q_reg         <= '0;
         r_reg         <= '0;
         d_reg         <= '0;
         cnt           <= '0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  if (divisor_i != '0) begin
                     state         <= ST_CALC;
                     q_reg         <= dividend_i;
                     r_reg         <= '0;
                     d_reg         <= divisor_i;
                     cnt           <= '0;
                     div_by_zero_o <= 1'b0;
                  end else begin
                     state         <= ST_DONE;
                     quotient_o    <= '1;
                     remainder_o   <= dividend_i;
                     div_by_zero_o <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               q_reg <= q_next;
               r_reg <= r_next;
               if (last_iter) begin
                  state       <= ST_DONE;
                  quotient_o  <= q_next;
                  remainder_o <= r_next;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_divider_8bit.sv
// Self-checking bench for sequence_divider_8bit: table-driven vectors,
// hand-written multi-cycle corner cases and random operands, all checked
// through a scoreboard of expected results and done_o edge numbers.

module tb_sequence_divider_8bit;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [7:0] dividend_i;
   logic [7:0] divisor_i;
   logic       busy_o;
   logic       done_o;
   logic [7:0] quotient_o;
   logic [7:0] remainder_o;
   logic       div_by_zero_o;

   int checks   = 0;
   int errors   = 0;
   int edge_cnt = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      logic [7:0] dividend;
      logic [7:0] divisor;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      int         edge_no;
   } sb_t;

   typedef struct {
      logic [7:0] dividend;
      logic [7:0] divisor;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } vec_t;

   sb_t  sb[$];
   sb_t  mon_e;
   vec_t vecs[10];

   sequence_divider_8bit #(.WIDTH(8)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .div_by_zero_o (div_by_zero_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Count rising edges so latency can be expressed in edge numbers
   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, edge_cnt);
      end
   endtask

   // Drive one start pulse; optionally record the expected result and the
   // edge count at which done_o should first be observed
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] eq, input logic [7:0] er,
                                input logic edbz, input bit track);
      sb_t e;
      start_i    = 1'b1;
      dividend_i = a;
      divisor_i  = b;
      if (track) begin
         e.dividend = a;
         e.divisor  = b;
         e.q        = eq;
         e.r        = er;
         e.dbz      = edbz;
         e.edge_no  = edge_cnt + 1 + ((b == 8'd0) ? 0 : 8);
         sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   // Wait until every expected result has been consumed, with a cycle bound
   task automatic waitIdle();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         checkOutput("done_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   // Reference division used for random operands
   task automatic applyRandom(input logic [7:0] a, input logic [7:0] b);
      if (b == 8'd0) applyStimulus(a, b, 8'hFF, a, 1'b1, 1'b1);
      else           applyStimulus(a, b, a / b, a % b, 1'b0, 1'b1);
   endtask

   // Monitor on the falling edge: count busy cycles and compare each done_o
   // pulse against the oldest scoreboard entry
   always @(negedge clk_i) begin
      if (busy_o === 1'b1) busy_cnt++;
      if (done_o === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("quotient", int'(quotient_o), int'(mon_e.q));
            checkOutput("remainder", int'(remainder_o), int'(mon_e.r));
            checkOutput("div_by_zero", int'(div_by_zero_o), int'(mon_e.dbz));
            checkOutput("latency_edge", edge_cnt, mon_e.edge_no);
            if (mon_e.divisor != 8'd0) begin
               checkOutput("invariant", int'(quotient_o) * int'(mon_e.divisor) + int'(remainder_o),
                           int'(mon_e.dividend));
               checkOutput("rem_lt_div", int'(remainder_o < mon_e.divisor), 1);
            end
         end
      end
   end

   // Hard stop in case something wedges the stimulus sequence
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Main stimulus sequence
   initial begin
      int done_before;
      logic [7:0] ra;
      logic [7:0] rb;

      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[4] = '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0};
      vecs[5] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1};
      vecs[6] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0};
      vecs[7] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
      vecs[8] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
      vecs[9] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};

      rst_ni     = 1'b0;
      start_i    = 1'b0;
      dividend_i = 8'd0;
      divisor_i  = 8'd0;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset_busy", int'(busy_o), 0);
      checkOutput("reset_done", int'(done_o), 0);
      checkOutput("reset_quotient", int'(quotient_o), 0);
      checkOutput("reset_remainder", int'(remainder_o), 0);
      checkOutput("reset_dbz", int'(div_by_zero_o), 0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Table of directed vectors
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].q, vecs[i].r, vecs[i].dbz, 1'b1);
         waitIdle();
      end

      // 200/7 keeps busy_o high for exactly WIDTH cycles
      busy_cnt = 0;
      applyStimulus(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
      waitIdle();
      checkOutput("busy_cycles_200_7", busy_cnt, 8);

      // Divide by zero never raises busy_o; next op clears the flag
      busy_cnt = 0;
      applyStimulus(8'd100, 8'd0, 8'hFF, 8'd100, 1'b1, 1'b1);
      waitIdle();
      checkOutput("busy_cycles_dbz", busy_cnt, 0);
      applyStimulus(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b1);
      waitIdle();

      // Back-to-back: second start held high during the DONE cycle
      applyStimulus(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
      repeat (8) begin
         @(posedge clk_i);
         #1;
      end
      applyStimulus(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b1);
      waitIdle();

      // Start pulsed mid-CALC must be ignored
      applyStimulus(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
      repeat (3) begin
         @(posedge clk_i);
         #1;
      end
      start_i    = 1'b1;
      dividend_i = 8'd50;
      divisor_i  = 8'd6;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      waitIdle();

      // Reset during CALC aborts the operation with no done_o
      done_before = done_cnt;
      applyStimulus(8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk_i);
         #1;
      end
      rst_ni = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("abort_busy", int'(busy_o), 0);
      checkOutput("abort_done", int'(done_o), 0);
      checkOutput("abort_quotient", int'(quotient_o), 0);
      checkOutput("abort_remainder", int'(remainder_o), 0);
      checkOutput("abort_dbz", int'(div_by_zero_o), 0);
      rst_ni = 1'b1;
      repeat (15) @(posedge clk_i);
      #1;
      checkOutput("abort_no_done", done_cnt, done_before);
      checkOutput("abort_idle_busy", int'(busy_o), 0);

      // Random operands biased toward 0 and 255
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0:       ra = 8'd0;
            1:       ra = 8'd255;
            default: ra = 8'($urandom_range(0, 255));
         endcase
         case ($urandom_range(0, 5))
            0:       rb = 8'd0;
            1:       rb = 8'd255;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         applyRandom(ra, rb);
         waitIdle();
      end

      repeat (3) @(posedge clk_i);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
